rom_access_arbiter: RTL and testbench
=====================================

Name: rom_access_arbiter

Overview:
Shares one synchronous user-ID ROM between two requesters, for example the player-1 and player-2 login controllers.
- Requesters present an address and hold a request.
- The arbiter grants round-robin, drives the ROM address and waits out the ROM latency.
- It captures the ROM word and returns it with a one-cycle response pulse.
- One transaction is outstanding at a time. Responses are never reordered.

Parameters:
- ADDR_W, 5: ROM address width.
- DATA_W, 4: ROM data width (one password digit).
- ROM_LAT, 2: clock edges after rom_addr changes until rom_data is valid. Legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held until its rsp_valid0 is seen.
- addr0  in  ADDR_W  requester 0 address; stable while req0 is high.
- req1  in  1  requester 1 request.
- addr1  in  ADDR_W  requester 1 address.
- rom_data  in  DATA_W  ROM read data.
- rom_addr  out  ADDR_W  registered ROM address.
- gnt0  out  1  requester 0 owns the current transaction.
- gnt1  out  1  requester 1 owns the current transaction.
- rsp_valid0  out  1  one-cycle pulse; rsp_data0 is valid.
- rsp_data0  out  DATA_W  captured word for requester 0; held until its next response.
- rsp_valid1  out  1  as rsp_valid0, for requester 1.
- rsp_data1  out  DATA_W  as rsp_data0, for requester 1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - rom_addr, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1 and busy all go to 0.
  - Wait counter goes to 0. last_gnt goes to 1, so requester 0 wins first.
  - Reset mid-transaction abandons it; no response is ever issued for it.
- State IDLE, at each edge:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester other than last_gnt.
  - On a grant: rom_addr <= addr of winner; gnt_x <= 1; last_gnt <= winner; counter <= ROM_LAT; go to WAIT.
  - No request: stay in IDLE.
- State WAIT:
  - Counter decrements each edge. rom_addr and gnt_x are held.
  - Edge when counter == 0: rsp_data_x <= rom_data; rsp_valid_x <= 1; go to DONE.
- State DONE (exactly one cycle):
  - rsp_valid_x is high for this cycle only.
  - Next edge: rsp_valid_x <= 0; gnt_x <= 0; go to IDLE.
  - req inputs are ignored in DONE, so a requester that deasserts on seeing rsp_valid is never double-served.
- Latency: request sampled at edge E0 gives rsp_valid rising at E0+ROM_LAT+1. The earliest next grant is sampled at E0+ROM_LAT+3.
- A requester dropping req during WAIT does not abort the transaction; its response still pulses.
- Address change during WAIT is ignored, because the address was captured at grant.
- Never both gnt0 and gnt1 high. Never both rsp_valid high.
- No wrap-around concerns: the counter counts down only from ROM_LAT.
- rom_addr keeps its last value in IDLE.

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- Enabled:
  - Adds inputs lock0 and lock1, 1 bit each.
  - If lock_x is high when DONE returns to IDLE, ownership is retained: in IDLE only requester x can be granted, even if the other is requesting.
  - This gives the 4-digit password burst uninterrupted access.
  - Ownership is released at the first IDLE edge with lock_x low.
  - Reset clears ownership.
- Disabled: no lock ports; pure round-robin, as described above.

Test Plan:
1. Reset asserted with no clock running -> all outputs 0 immediately; release reset with no req -> busy stays 0.
2. ROM[2]=4'h7, ROM_LAT=2; req0=1, addr0=2 sampled at E0 -> rom_addr=2 and gnt0=1 after E0; rsp_valid0 high for exactly the cycle after E0+3; rsp_data0=4'h7; busy falls after E0+4.
3. After reset, req0 and req1 both high at E0; ROM[1]=4'h3, ROM[4]=4'h9 -> requester 0 served first (rsp_data0=3 at E0+3); requester 1 granted at E0+5 (rsp_data1=9 at E0+8); gnt0 and gnt1 never overlap.
4. req1 held high continuously while req0 re-requests after each response -> grants alternate 0,1,0,1; neither requester is served twice in a row.
5. Assert reset while in WAIT -> rsp_valid never pulses; after reset release the state is IDLE and the next grant goes to requester 0.
6. ROM_ARB_LOCK_EN, lock0=1, req0 issues addresses 0,1,2,3 while req1 stays high -> four requester-0 responses back to back; requester 1 granted only after lock0 falls.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two requesters.
// Define ROM_ARB_LOCK_EN to add lock0/lock1 burst ownership.
module rom_access_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
`ifdef ROM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid0,
  output logic [DATA_W-1:0] rsp_data0,
  output logic              rsp_valid1,
  output logic [DATA_W-1:0] rsp_data1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(ROM_LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       last_gnt;
  logic       hold;
  logic       hold_id;
  logic       pick0;
  logic       pick1;

`ifdef ROM_ARB_LOCK_EN
  logic own_vld;
  logic own_id;

  assign hold    = own_vld && (own_id ? lock1 : lock0);
  assign hold_id = own_id;
`else
  assign hold    = 1'b0;
  assign hold_id = 1'b0;
`endif

  // a held lock restricts arbitration to the owner alone
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (hold) begin
      pick0 = !hold_id && req0;
      pick1 = hold_id && req1;
    end else if (req0 && req1) begin
      pick0 = last_gnt;
      pick1 = !last_gnt;
    end else begin
      pick0 = req0;
      pick1 = req1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_gnt   <= 1'b1;
      rom_addr   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data0  <= '0;
      rsp_data1  <= '0;
      busy       <= 1'b0;
`ifdef ROM_ARB_LOCK_EN
      own_vld    <= 1'b0;
      own_id     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
`ifdef ROM_ARB_LOCK_EN
          own_vld <= hold;
`endif
          if (pick0 || pick1) begin
            rom_addr <= pick0 ? addr0 : addr1;
            gnt0     <= pick0;
            gnt1     <= pick1;
            last_gnt <= pick1;
            cnt      <= LAT;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (gnt0) begin
              rsp_valid0 <= 1'b1;
              rsp_data0  <= rom_data;
            end else begin
              rsp_valid1 <= 1'b1;
              rsp_data1  <= rom_data;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
`ifdef ROM_ARB_LOCK_EN
          if (gnt0 && lock0) begin
            own_vld <= 1'b1;
            own_id  <= 1'b0;
          end else if (gnt1 && lock1) begin
            own_vld <= 1'b1;
            own_id  <= 1'b1;
          end
`endif
          rsp_valid0 <= 1'b0;
          rsp_valid1 <= 1'b0;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: transaction-level model plus ROM model.
// Lock scenario runs when ROM_ARB_LOCK_EN is defined.
module tb_rom_access_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] rom_addr;
  logic          gnt0, gnt1;
  logic          rsp_valid0, rsp_valid1;
  logic [DW-1:0] rsp_data0, rsp_data1;
  logic          busy;
`ifdef ROM_ARB_LOCK_EN
  logic          lock0 = 1'b0;
  logic          lock1 = 1'b0;
`endif

  bit clk_run = 1'b0;
  int tests = 0;
  int fails = 0;

  logic [DW-1:0] rom [32];
  logic [DW-1:0] pipe [LAT];

  bit            last;
  logic [DW-1:0] exp_d [2];
  bit            own_v;
  bit            own_i;

  rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .addr0(addr0),
    .req1(req1),
    .addr1(addr1),
`ifdef ROM_ARB_LOCK_EN
    .lock0(lock0),
    .lock1(lock1),
`endif
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .rsp_valid0(rsp_valid0),
    .rsp_data0(rsp_data0),
    .rsp_valid1(rsp_valid1),
    .rsp_data1(rsp_data1),
    .busy(busy)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  // data valid LAT edges after the address changes
  always @(posedge clk) begin
    pipe[0] <= rom[rom_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_data = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset === 1'b1)
      chk("exclusive", 32'({gnt0 & gnt1, rsp_valid0 & rsp_valid1}), 0);

  task automatic chk_zero(input string tag);
    chk(tag, 32'({rom_addr, gnt0, gnt1, rsp_valid0, rsp_valid1,
                  rsp_data0, rsp_data1, busy}), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk_zero("reset_async");
    tick();
    reset = 1'b1;
    last = 1'b1;
    own_v = 1'b0;
    exp_d[0] = '0;
    exp_d[1] = '0;
    tick();
  endtask

  // one transaction: from an IDLE cycle through DONE back to IDLE
  task automatic txn(input bit r0, input bit r1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bit h0, h1, w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    req0 = r0;
    req1 = r1;
    addr0 = a0;
    addr1 = a1;
    h0 = r0;
    h1 = r1;
`ifdef ROM_ARB_LOCK_EN
    if (own_v) begin
      if (own_i ? lock1 : lock0) begin
        h0 = r0 && !own_i;
        h1 = r1 && own_i;
      end else begin
        own_v = 1'b0;
      end
    end
`endif
    tick();
    if (!h0 && !h1) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gnt", 32'({gnt1, gnt0}), 0);
      return;
    end
    w = (h0 && h1) ? !last : h1;
    wa = w ? a1 : a0;
    wd = rom[wa];
    chk("gnt", 32'({gnt1, gnt0}), w ? 2 : 1);
    chk("rom_addr", 32'(rom_addr), 32'(wa));
    chk("busy_on", 32'(busy), 1);
    for (int k = 0; k < LAT; k++) begin
      if ($urandom % 2 == 0) begin
        if (w) addr1 = AW'($urandom);
        else   addr0 = AW'($urandom);
      end
      if ($urandom % 4 == 0) begin
        if (w) req1 = 1'b0;
        else   req0 = 1'b0;
      end
      tick();
      chk("wait_rsp", 32'({rsp_valid1, rsp_valid0}), 0);
      chk("wait_gnt", 32'({gnt1, gnt0}), w ? 2 : 1);
      chk("wait_addr", 32'(rom_addr), 32'(wa));
    end
    tick();
    exp_d[w] = wd;
    chk("rsp_valid", 32'({rsp_valid1, rsp_valid0}), w ? 2 : 1);
    chk("rsp_data0", 32'(rsp_data0), 32'(exp_d[0]));
    chk("rsp_data1", 32'(rsp_data1), 32'(exp_d[1]));
    if (w) req1 = 1'b0;
    else   req0 = 1'b0;
    tick();
    chk("done_clr", 32'({busy, gnt1, gnt0, rsp_valid1, rsp_valid0}), 0);
`ifdef ROM_ARB_LOCK_EN
    if (w ? lock1 : lock0) begin
      own_v = 1'b1;
      own_i = w;
    end
`endif
    last = w;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
    rom[1] = 4'h3;
    rom[2] = 4'h7;
    rom[4] = 4'h9;
    req0 = 1'b0;
    req1 = 1'b0;
    addr0 = '0;
    addr1 = '0;
    reset = 1'b0;
    #2;
    chk_zero("reset_noclk");
    clk_run = 1'b1;
    tick();
    reset = 1'b1;
    last = 1'b1;
    own_v = 1'b0;
    exp_d[0] = '0;
    exp_d[1] = '0;
    tick();
    tick();
    chk("no_req_busy", 32'(busy), 0);

    txn(1'b1, 1'b0, 5'd2, 5'd0);
    chk("rom2_data", 32'(exp_d[0]), 32'h7);

    do_reset();
    txn(1'b1, 1'b1, 5'd1, 5'd4);
    txn(1'b0, 1'b1, 5'd0, 5'd4);

    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, AW'($urandom), AW'($urandom));

    req0 = 1'b1;
    addr0 = 5'd5;
    req1 = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_zero("reset_mid_wait");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_no_rsp", 32'({rsp_valid1, rsp_valid0, busy}), 0);
    end
    reset = 1'b1;
    last = 1'b1;
    own_v = 1'b0;
    exp_d[0] = '0;
    exp_d[1] = '0;
    txn(1'b1, 1'b1, 5'd6, 5'd7);

    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom));

`ifdef ROM_ARB_LOCK_EN
    do_reset();
    lock0 = 1'b1;
    for (int a = 0; a < 4; a++)
      txn(1'b1, 1'b1, AW'(a), 5'd9);
    lock0 = 1'b0;
    txn(1'b1, 1'b1, 5'd3, 5'd9);
    chk("lock_release", 32'(last), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
